jtag_dbg_sched: RTL and testbench
=================================

# jtag_dbg_sched

Command scheduler between the JTAG data-register core (8-bit data + 3-bit address, update strobe, TCK domain) and the system clock domain. It synchronises each JTAG update and decodes the 3-bit address as a command. It then sequences the command either to a UART-TX stream or to a byte-wide debug bus master with a timeout. Status and read data are returned on the core's capture inputs so the host can poll them on the next DR scan.

## Interface
- TIMEOUT, 255, bus-ack timeout in clk cycles (1..65535).
- ADDR_AUTOINC, 1, 1 = increment bus address after each successful bus access.

- clk  in  1  system clock
- reset  in  1  synchronous, active-high.
- jtag_update  in  1  reg_update from JTAG core (TCK domain, level ≥ 2 clk periods)
- jtag_q  in  8  reg_q (stable from before update until next DR scan)
- jtag_addr_q  in  3  reg_addr_q (command code)
- jtag_d  out  8  to reg_d: last read byte
- jtag_addr_d  out  3  to reg_addr_d: {busy, err, tx_ovr}
- tx_data  out  8  UART TX byte
- tx_valid  out  1  UART TX valid
- tx_ready  in  1  UART TX ready
- bus_req  out  1  debug-bus request
- bus_we  out  1  1 = write
- bus_adr  out  32  byte address
- bus_dat_o  out  8  write data
- bus_dat_i  in  8  read data (valid with bus_ack)
- bus_ack  in  1  access complete

## Operation
- jtag_update passes through a 3-flop synchroniser, then a rising-edge detector. Each edge produces one cmd_stb. jtag_q and jtag_addr_q are sampled into cmd_dat/cmd_op on cmd_stb, with no extra synchronisation; they are quasi-static.
- Command codes:
  - 0 TX: send cmd_dat to UART.
  - 1 ADR: bus_adr <= {bus_adr[23:0], cmd_dat}.
  - 2 WR: byte write of cmd_dat at bus_adr.
  - 3 RD: byte read at bus_adr; result to jtag_d.
  - 4 CLR: clear err and tx_ovr.
  - 5-7: no-op.
- FSM states:
  - IDLE: on cmd_stb, go to DECODE.
  - DECODE: TX goes to TXW. WR and RD go to BUS. ADR and CLR complete here and return to IDLE.
  - TXW: tx_valid=1 until tx_valid&tx_ready, then IDLE.
  - BUS: bus_req=1, counter runs. On bus_ack, latch bus_dat_i into jtag_d if RD, autoincrement, then IDLE. If the counter reaches TIMEOUT without ack, set err, drop bus_req, do not increment, then IDLE.
- busy = (state != IDLE).
- cmd_stb while busy: the command is dropped and tx_ovr is set, whatever the op. busy tells the host not to issue commands.
- tx_ovr and err are sticky. They are cleared only by CLR or reset.
- bus_adr wraps 0xFFFFFFFF -> 0 on increment.
- Reset: state IDLE, synchroniser 0, all outputs 0 (jtag_d=0, jtag_addr_d=0, tx_valid=0, bus_req=0, bus_we=0, bus_adr=0, bus_dat_o=0). A reset during TXW or BUS abandons the transfer immediately; valid/req are 0 on the next cycle.

## Timing
- jtag_update rising at clk edge N gives cmd_stb at N+3. cmd_dat and state=DECODE are visible at N+4.
- TX: tx_valid rises at N+5. tx_data/tx_valid are held stable until the handshake cycle and are 0 the cycle after.
- WR/RD: bus_req, bus_we, bus_adr and bus_dat_o are asserted at N+5 and held constant until the ack cycle or timeout. bus_req deasserts the cycle after ack. An ack while bus_req=0 is ignored.
- Timeout: the counter starts at 0 in the first BUS cycle. The error is flagged when it equals TIMEOUT with no ack. bus_req is low TIMEOUT+1 cycles after entry.
- An ack in the same cycle the counter hits TIMEOUT counts as success; err stays clear.
- ADR/CLR are effective at N+5 (busy for one cycle).
- jtag_d and jtag_addr_d change only on clk edges. The host must poll until busy=0 and then read jtag_d on a later scan.

## Test plan
- Reset, then idle 10 cycles -> all outputs 0, busy=0.
- ADR 0x12,0x34,0x56,0x78, then WR 0xAB, ack after 2 cycles -> bus_adr=0x12345678, bus_we=1, bus_dat_o=0xAB. bus_adr=0x12345679 afterwards.
- RD with bus_dat_i=0x5C, ack after 4 cycles -> jtag_d=0x5C, jtag_addr_d=3'b000. The next RD is issued at address +1.
- TX 0x41 with tx_ready held low 20 cycles, plus a second update during the wait -> tx_data=0x41 held stable, second command dropped, tx_ovr=1. After tx_ready, one transfer only. CLR -> tx_ovr=0.
- WR with no ack, TIMEOUT=8 -> bus_req high 9 cycles, err=1, bus_adr unchanged. Ack exactly at counter=8 -> err=0.
- Assert reset mid-BUS and mid-TXW -> bus_req/tx_valid low the next cycle, state IDLE, flags 0. Wrap test: ADR 0xFF×4, WR -> bus_adr=0x00000000.

Source files
------------

// File: rtl/jtag_dbg_sched_if.sv
// UART-TX stream and byte-wide debug bus driven by the JTAG command scheduler.
interface jtag_dbg_sched_if;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_adr;
  logic [7:0]  bus_dat_o;
  logic [7:0]  bus_dat_i;
  logic        bus_ack;

  modport master (
    output tx_data, tx_valid, bus_req, bus_we, bus_adr, bus_dat_o,
    input  tx_ready, bus_dat_i, bus_ack
  );

  modport slave (
    input  tx_data, tx_valid, bus_req, bus_we, bus_adr, bus_dat_o,
    output tx_ready, bus_dat_i, bus_ack
  );
endinterface

// File: rtl/jtag_dbg_sched.sv
// Synchronises JTAG DR updates into clk and sequences each decoded command to
// the UART-TX stream or the debug bus; status/read data go back to the DR capture.
module jtag_dbg_sched #(
  parameter int unsigned TIMEOUT      = 255,
  parameter bit          ADDR_AUTOINC = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       jtag_update,
  input  logic [7:0] jtag_q,
  input  logic [2:0] jtag_addr_q,
  output logic [7:0] jtag_d,
  output logic [2:0] jtag_addr_d,
  jtag_dbg_sched_if.master dbg
);

  typedef enum logic [1:0] {IDLE, DECODE, TXW, BUS} state_e;
  typedef enum logic [2:0] {
    OP_TX  = 3'd0,
    OP_ADR = 3'd1,
    OP_WR  = 3'd2,
    OP_RD  = 3'd3,
    OP_CLR = 3'd4
  } op_e;

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  state_e      state_q, state_d;
  op_e         cmd_op;
  logic [7:0]  cmd_dat;
  logic [2:0]  sync_q;
  logic        sync_prev;
  logic        cmd_stb;
  logic [15:0] cnt;
  logic [31:0] adr_q;
  logic [7:0]  rd_q;
  logic        err_q;
  logic        ovr_q;
  logic        busy;
  logic        tmo_hit;

  assign busy        = (state_q != IDLE);
  assign tmo_hit     = (cnt == TMO);
  assign jtag_d      = rd_q;
  assign jtag_addr_d = {busy, err_q, ovr_q};
  assign dbg.bus_adr = adr_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    dbg.tx_valid  = 1'b0;
    dbg.tx_data   = '0;
    dbg.bus_req   = 1'b0;
    dbg.bus_we    = 1'b0;
    dbg.bus_dat_o = '0;
    case (state_q)
      IDLE: if (cmd_stb) state_d = DECODE;
      DECODE: begin
        case (cmd_op)
          OP_TX:        state_d = TXW;
          OP_WR, OP_RD: state_d = BUS;
          default:      state_d = IDLE;
        endcase
      end
      TXW: begin
        dbg.tx_valid = 1'b1;
        dbg.tx_data  = cmd_dat;
        if (dbg.tx_ready) state_d = IDLE;
      end
      BUS: begin
        dbg.bus_req   = 1'b1;
        dbg.bus_we    = (cmd_op == OP_WR);
        dbg.bus_dat_o = (cmd_op == OP_WR) ? cmd_dat : '0;
        if (dbg.bus_ack || tmo_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '0;
      sync_prev <= 1'b0;
      cmd_stb   <= 1'b0;
      cmd_op    <= OP_TX;
      cmd_dat   <= '0;
      cnt       <= '0;
      adr_q     <= '0;
      rd_q      <= '0;
      err_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      sync_q    <= {sync_q[1:0], jtag_update};
      sync_prev <= sync_q[2];
      cmd_stb   <= sync_q[2] & ~sync_prev;

      if (state_q == DECODE)   cnt <= '0;
      else if (state_q == BUS) cnt <= cnt + 16'd1;

      if (state_q == IDLE && cmd_stb) begin
        cmd_dat <= jtag_q;
        cmd_op  <= op_e'(jtag_addr_q);
      end

      if (state_q == DECODE) begin
        if (cmd_op == OP_ADR) adr_q <= {adr_q[23:0], cmd_dat};
        if (cmd_op == OP_CLR) begin
          err_q <= 1'b0;
          ovr_q <= 1'b0;
        end
      end

      // An ack coinciding with the timeout count still wins.
      if (state_q == BUS) begin
        if (dbg.bus_ack) begin
          if (cmd_op == OP_RD) rd_q <= dbg.bus_dat_i;
          if (ADDR_AUTOINC)    adr_q <= adr_q + 32'd1;
        end else if (tmo_hit) begin
          err_q <= 1'b1;
        end
      end

      // Placed after CLR so a command dropped in the CLR decode cycle still flags.
      if (cmd_stb && state_q != IDLE) ovr_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jtag_dbg_sched.sv
// Scoreboard bench for jtag_dbg_sched: expected bus/TX/read results are queued at
// command issue and compared when the DUT presents the matching transfer.
module tb_jtag_dbg_sched;

  localparam logic [2:0] C_TX  = 3'd0;
  localparam logic [2:0] C_ADR = 3'd1;
  localparam logic [2:0] C_WR  = 3'd2;
  localparam logic [2:0] C_RD  = 3'd3;
  localparam logic [2:0] C_CLR = 3'd4;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [7:0]  dat;
  } bus_exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       jtag_update;
  logic [7:0] jtag_q;
  logic [2:0] jtag_addr_q;
  logic [7:0] jtag_d;
  logic [2:0] jtag_addr_d;

  jtag_dbg_sched_if dbg ();

  jtag_dbg_sched #(.TIMEOUT(8), .ADDR_AUTOINC(1'b1)) dut (
    .clk         (clk),
    .reset       (reset),
    .jtag_update (jtag_update),
    .jtag_q      (jtag_q),
    .jtag_addr_q (jtag_addr_q),
    .jtag_d      (jtag_d),
    .jtag_addr_d (jtag_addr_d),
    .dbg         (dbg)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_adr = '0;
  bus_exp_t    bus_q[$];
  logic [7:0]  rd_q[$];
  logic [7:0]  tx_q[$];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic jtag_cmd(input logic [2:0] op, input logic [7:0] dat);
    jtag_addr_q = op;
    jtag_q      = dat;
    jtag_update = 1'b1;
    repeat (3) @(negedge clk);
    jtag_update = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (jtag_addr_d[2] !== 1'b0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (jtag_addr_d[2] !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle: busy=%b required 0", tag, jtag_addr_d[2]);
    end
  endtask

  task automatic serve(input string tag, input int delay, input logic [7:0] rdata);
    bus_exp_t e;
    int n = 0;
    while (dbg.bus_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (dbg.bus_req !== 1'b1 || bus_q.size() == 0) begin
      bad++;
      $display("FAIL %s_req: bus_req=%b queued=%0d required req=1", tag, dbg.bus_req, bus_q.size());
      return;
    end
    e = bus_q.pop_front();
    for (int k = 0; k <= delay; k++) begin
      total++;
      if (dbg.bus_req !== 1'b1 || dbg.bus_we !== e.we || dbg.bus_adr !== e.adr ||
          (e.we && dbg.bus_dat_o !== e.dat)) begin
        bad++;
        $display("FAIL %s_hold%0d: req=%b we=%b adr=%h dat=%h required req=1 we=%b adr=%h dat=%h",
                 tag, k, dbg.bus_req, dbg.bus_we, dbg.bus_adr, dbg.bus_dat_o, e.we, e.adr, e.dat);
      end
      if (k == delay) begin
        dbg.bus_ack   = 1'b1;
        dbg.bus_dat_i = rdata;
      end
      @(negedge clk);
    end
    dbg.bus_ack   = 1'b0;
    dbg.bus_dat_i = 8'h00;
    total++;
    if (dbg.bus_req !== 1'b0) begin
      bad++;
      $display("FAIL %s_drop: bus_req=%b required 0", tag, dbg.bus_req);
    end
  endtask

  task automatic adr_byte(input logic [7:0] b);
    jtag_cmd(C_ADR, b);
    m_adr = {m_adr[23:0], b};
    wait_idle("adr");
  endtask

  task automatic test_reset;
    reset = 1'b1; jtag_update = 1'b0; jtag_q = '0; jtag_addr_q = '0;
    dbg.tx_ready = 1'b0; dbg.bus_ack = 1'b0; dbg.bus_dat_i = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    m_adr = '0;
    total++;
    if (jtag_d !== 8'h00 || jtag_addr_d !== 3'b000) begin
      bad++;
      $display("FAIL reset_jtag: jtag_d=%h addr_d=%b required 00 000", jtag_d, jtag_addr_d);
    end
    total++;
    if (dbg.tx_valid !== 1'b0 || dbg.tx_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_tx: valid=%b data=%h required 0 00", dbg.tx_valid, dbg.tx_data);
    end
    total++;
    if (dbg.bus_req !== 1'b0 || dbg.bus_we !== 1'b0 || dbg.bus_adr !== 32'h0 || dbg.bus_dat_o !== 8'h00) begin
      bad++;
      $display("FAIL reset_bus: req=%b we=%b adr=%h dat=%h required all 0",
               dbg.bus_req, dbg.bus_we, dbg.bus_adr, dbg.bus_dat_o);
    end
  endtask

  task automatic test_write;
    adr_byte(8'h12); adr_byte(8'h34); adr_byte(8'h56); adr_byte(8'h78);
    bus_q.push_back('{we: 1'b1, adr: m_adr, dat: 8'hAB});
    jtag_cmd(C_WR, 8'hAB);
    serve("wr", 2, 8'h00);
    m_adr = m_adr + 32'd1;
    wait_idle("wr");
    total++;
    if (dbg.bus_adr !== 32'h12345679) begin
      bad++;
      $display("FAIL wr_autoinc: bus_adr=%h required 12345679", dbg.bus_adr);
    end
  endtask

  task automatic test_read;
    logic [7:0] exp;
    bus_q.push_back('{we: 1'b0, adr: m_adr, dat: 8'h00});
    rd_q.push_back(8'h5C);
    jtag_cmd(C_RD, 8'h00);
    serve("rd1", 4, 8'h5C);
    m_adr = m_adr + 32'd1;
    wait_idle("rd1");
    exp = rd_q.pop_front();
    total++;
    if (jtag_d !== exp || jtag_addr_d !== 3'b000) begin
      bad++;
      $display("FAIL rd1_data: jtag_d=%h addr_d=%b required %h 000", jtag_d, jtag_addr_d, exp);
    end
    bus_q.push_back('{we: 1'b0, adr: m_adr, dat: 8'h00});
    rd_q.push_back(8'hA5);
    jtag_cmd(C_RD, 8'h00);
    serve("rd2", 1, 8'hA5);
    m_adr = m_adr + 32'd1;
    wait_idle("rd2");
    exp = rd_q.pop_front();
    total++;
    if (jtag_d !== exp || dbg.bus_adr !== m_adr) begin
      bad++;
      $display("FAIL rd2_data: jtag_d=%h adr=%h required %h %h", jtag_d, dbg.bus_adr, exp, m_adr);
    end
  endtask

  task automatic test_tx_overrun;
    logic [7:0] exp;
    int extra = 0;
    tx_q.push_back(8'h41);
    dbg.tx_ready = 1'b0;
    jtag_cmd(C_TX, 8'h41);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      total++;
      if (dbg.tx_valid !== 1'b1 || dbg.tx_data !== tx_q[0]) begin
        bad++;
        $display("FAIL tx_hold%0d: valid=%b data=%h required 1 %h", i, dbg.tx_valid, dbg.tx_data, tx_q[0]);
      end
      if (i == 10) jtag_cmd(C_ADR, 8'h99);
    end
    total++;
    if (jtag_addr_d !== 3'b101 || dbg.bus_adr !== m_adr) begin
      bad++;
      $display("FAIL tx_ovr: addr_d=%b adr=%h required 101 %h", jtag_addr_d, dbg.bus_adr, m_adr);
    end
    dbg.tx_ready = 1'b1;
    exp = tx_q.pop_front();
    total++;
    if (dbg.tx_valid !== 1'b1 || dbg.tx_data !== exp) begin
      bad++;
      $display("FAIL tx_hs: valid=%b data=%h required 1 %h", dbg.tx_valid, dbg.tx_data, exp);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (dbg.tx_valid === 1'b1 || dbg.tx_data !== 8'h00) extra++;
    end
    dbg.tx_ready = 1'b0;
    total++;
    if (extra != 0 || jtag_addr_d !== 3'b001) begin
      bad++;
      $display("FAIL tx_single: extra_cycles=%0d addr_d=%b required 0 001", extra, jtag_addr_d);
    end
    jtag_cmd(C_CLR, 8'h00);
    wait_idle("clr");
    total++;
    if (jtag_addr_d !== 3'b000) begin
      bad++;
      $display("FAIL tx_clr: addr_d=%b required 000", jtag_addr_d);
    end
  endtask

  task automatic test_timeout;
    int hi = 0;
    jtag_cmd(C_WR, 8'h77);
    @(negedge clk);
    total++;
    if (dbg.bus_req !== 1'b1) begin
      bad++;
      $display("FAIL tmo_start: bus_req=%b required 1", dbg.bus_req);
    end
    while (dbg.bus_req === 1'b1 && hi < 40) begin
      hi++;
      @(negedge clk);
    end
    wait_idle("tmo");
    total++;
    if (hi != 9 || jtag_addr_d !== 3'b010 || dbg.bus_adr !== m_adr) begin
      bad++;
      $display("FAIL tmo_err: req_cycles=%0d addr_d=%b adr=%h required 9 010 %h", hi, jtag_addr_d, dbg.bus_adr, m_adr);
    end
    jtag_cmd(C_CLR, 8'h00);
    wait_idle("tmo_clr");
    bus_q.push_back('{we: 1'b1, adr: m_adr, dat: 8'h3C});
    jtag_cmd(C_WR, 8'h3C);
    serve("tmo_edge", 8, 8'h00);
    m_adr = m_adr + 32'd1;
    wait_idle("tmo_edge");
    total++;
    if (jtag_addr_d !== 3'b000 || dbg.bus_adr !== m_adr) begin
      bad++;
      $display("FAIL tmo_edge_ok: addr_d=%b adr=%h required 000 %h", jtag_addr_d, dbg.bus_adr, m_adr);
    end
  endtask

  task automatic test_reset_mid;
    jtag_cmd(C_WR, 8'h11);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (dbg.bus_req !== 1'b1) begin
      bad++;
      $display("FAIL rstbus_pre: bus_req=%b required 1", dbg.bus_req);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_adr = '0;
    total++;
    if (dbg.bus_req !== 1'b0 || dbg.bus_we !== 1'b0 || dbg.bus_adr !== 32'h0 || jtag_addr_d !== 3'b000) begin
      bad++;
      $display("FAIL rstbus: req=%b we=%b adr=%h addr_d=%b required 0 0 0 000",
               dbg.bus_req, dbg.bus_we, dbg.bus_adr, jtag_addr_d);
    end
    repeat (4) @(negedge clk);
    dbg.tx_ready = 1'b0;
    jtag_cmd(C_TX, 8'h55);
    jtag_cmd(C_TX, 8'h66);
    total++;
    if (dbg.tx_valid !== 1'b1 || jtag_addr_d !== 3'b101) begin
      bad++;
      $display("FAIL rsttx_pre: valid=%b addr_d=%b required 1 101", dbg.tx_valid, jtag_addr_d);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (dbg.tx_valid !== 1'b0 || dbg.tx_data !== 8'h00 || jtag_addr_d !== 3'b000) begin
      bad++;
      $display("FAIL rsttx: valid=%b data=%h addr_d=%b required 0 00 000", dbg.tx_valid, dbg.tx_data, jtag_addr_d);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 4; i++) adr_byte(8'hFF);
    bus_q.push_back('{we: 1'b1, adr: m_adr, dat: 8'h5A});
    jtag_cmd(C_WR, 8'h5A);
    serve("wrap", 0, 8'h00);
    m_adr = m_adr + 32'd1;
    wait_idle("wrap");
    total++;
    if (dbg.bus_adr !== m_adr || m_adr !== 32'h0) begin
      bad++;
      $display("FAIL wrap_adr: bus_adr=%h required 00000000", dbg.bus_adr);
    end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_tx_overrun;
    test_timeout;
    test_reset_mid;
    test_wrap;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
